// File: rtl/rv32_decode_pkg.sv
// rtl/rv32_decode_pkg.sv - RV32I opcode constants and immediate-format helpers
// Purpose : shared decode definitions for the IF/ID buffer and its immediate generator.
// Contents: OP_* opcode localparams, imm_fmt_t, imm_fmt_of(), is_rv32i_opcode().
package rv32_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;

    // R-type, FENCE and unknown opcodes carry no immediate.
    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return IMM_I;
            OP_STORE:                            return IMM_S;
            OP_BRANCH:                           return IMM_B;
            OP_LUI, OP_AUIPC:                    return IMM_U;
            OP_JAL:                              return IMM_J;
            default:                             return IMM_NONE;
        endcase
    endfunction

    function automatic logic is_rv32i_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_SYSTEM, OP_FENCE: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/if_id_decode_buffer_if.sv
// rtl/if_id_decode_buffer_if.sv - fetch-in / decode-out handshake bundle
// Purpose : groups the Fetch beat (in_*) and decoded head entry (out_*) signals.
// Modports: slave  - the buffer (consumes in_*, drives out_* and in_ready)
//           master - the environment (drives in_* and out_ready)
// Config  : out_illegal exists only when DECODE_ILLEGAL_CHECK_EN is defined.
interface if_id_decode_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic        out_illegal;
`endif

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm
`ifdef DECODE_ILLEGAL_CHECK_EN
        , output out_illegal
`endif
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm
`ifdef DECODE_ILLEGAL_CHECK_EN
        , input out_illegal
`endif
    );
endinterface

// File: rtl/rv32_imm_gen.sv
// rtl/rv32_imm_gen.sv - combinational RV32I immediate generator
// Purpose : instruction word -> sign-extended immediate (and illegal flag).
// Ports   : inst_i [31:0] in, imm_o [31:0] out,
//           illegal_o out (only when DECODE_ILLEGAL_CHECK_EN is defined).
module rv32_imm_gen
    import rv32_decode_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,
    output logic        illegal_o
`endif
);

    always_comb begin
        imm_o = '0;
        case (imm_fmt_of(inst_i[6:0]))
            IMM_I:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                              inst_i[11:8], 1'b0};
            IMM_U:   imm_o = {inst_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                              inst_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign illegal_o = (inst_i[1:0] != 2'b11) || !is_rv32i_opcode(inst_i[6:0]);
`endif

endmodule

// File: rtl/if_id_decode_buffer.sv
// rtl/if_id_decode_buffer.sv - IF/ID decode buffer: FIFO of decoded fetch beats
// Purpose : accepts {pc, inst} beats, decodes the immediate at enqueue, queues them in a
//           DEPTH-entry FIFO and presents the head entry's fields downstream.
// Ports   : clk, reset (sync, active-high), flush (drop all entries),
//           bus (if_id_decode_buffer_if.slave): in_valid/in_ready/in_pc/in_inst,
//           out_valid/out_ready/out_pc/out_opcode/out_rd/out_funct3/out_rs1/out_rs2/
//           out_funct7/out_imm (+ out_illegal with DECODE_ILLEGAL_CHECK_EN).
// Params  : DEPTH (power of two, >= 2), XLEN (32 only).
module if_id_decode_buffer
    import rv32_decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    if_id_decode_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q,  count_d;
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] inst_q [DEPTH];
    logic [XLEN-1:0] imm_q  [DEPTH];
    logic [XLEN-1:0] wr_imm;
    logic [XLEN-1:0] head_inst;
    logic            push;
    logic            pop;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic            illegal_q [DEPTH];
    logic            wr_illegal;
`endif

    // Decode on the write side so the head entry's immediate is ready at the register output.
    rv32_imm_gen u_imm_gen (
        .inst_i    (bus.in_inst),
        .imm_o     (wr_imm)
`ifdef DECODE_ILLEGAL_CHECK_EN
        ,
        .illegal_o (wr_illegal)
`endif
    );

    assign bus.in_ready  = (count_q != FULL_CNT);
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Wrong-path entries and any same-cycle push/pop are discarded.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]      <= '0;
                inst_q[i]    <= '0;
                imm_q[i]     <= '0;
`ifdef DECODE_ILLEGAL_CHECK_EN
                illegal_q[i] <= 1'b0;
`endif
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push && !flush) begin
                pc_q[wr_ptr_q]      <= bus.in_pc;
                inst_q[wr_ptr_q]    <= bus.in_inst;
                imm_q[wr_ptr_q]     <= wr_imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
                illegal_q[wr_ptr_q] <= wr_illegal;
`endif
            end
        end
    end

    // Outputs always show the slot at rd_ptr, even when empty (don't-care then).
    assign head_inst      = inst_q[rd_ptr_q];
    assign bus.out_pc     = pc_q[rd_ptr_q];
    assign bus.out_imm    = imm_q[rd_ptr_q];
    assign bus.out_opcode = head_inst[6:0];
    assign bus.out_rd     = head_inst[11:7];
    assign bus.out_funct3 = head_inst[14:12];
    assign bus.out_rs1    = head_inst[19:15];
    assign bus.out_rs2    = head_inst[24:20];
    assign bus.out_funct7 = head_inst[31:25];
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign bus.out_illegal = illegal_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_if_id_decode_buffer.sv
// tb/tb_if_id_decode_buffer.sv - self-checking bench for if_id_decode_buffer
module tb_if_id_decode_buffer;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   n_checks = 0;
    int   n_pass   = 0;
    entry_t model_q[$];
    logic [31:0] pc_next;
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};

    if_id_decode_buffer_if bus ();

    if_id_decode_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Immediate from the ISA rules, using arithmetic shifts and masks.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [31:0] s;
        s = w;
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return 32'(s >>> 20);
            7'h23: return (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(w[11:7]);
            7'h63: return (32'(s >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11)
                          | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            7'h37, 7'h17: return w & 32'hFFFF_F000;
            7'h6F: return (32'(s >>> 11) & 32'hFFF0_0000) | (w & 32'h000F_F000)
                          | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [31:0] w);
        foreach (ops[k]) if (ops[k] == w[6:0]) return 1'b0;
        return 1'b1;
    endfunction

    // One cycle: drive at the falling edge, check before the rising edge, update model after it.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl, input logic rst);
        logic   do_push, do_pop;
        entry_t h;
        entry_t e;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = rdy;
        flush         = fl;
        reset         = rst;
        #1;
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = rdy && (model_q.size() != 0);
        if (!rst) begin
            check("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
            check("in_ready", 32'(bus.in_ready), 32'(model_q.size() < DEPTH));
            if (do_pop) begin
                h = model_q[0];
                check("pc", bus.out_pc, h.pc);
                check("opcode", 32'(bus.out_opcode), 32'(h.inst[6:0]));
                check("rd", 32'(bus.out_rd), 32'(h.inst[11:7]));
                check("funct3", 32'(bus.out_funct3), 32'(h.inst[14:12]));
                check("rs1", 32'(bus.out_rs1), 32'(h.inst[19:15]));
                check("rs2", 32'(bus.out_rs2), 32'(h.inst[24:20]));
                check("funct7", 32'(bus.out_funct7), 32'(h.inst[31:25]));
                check("imm", bus.out_imm, ref_imm(h.inst));
`ifdef DECODE_ILLEGAL_CHECK_EN
                check("illegal", 32'(bus.out_illegal), 32'(ref_illegal(h.inst)));
`endif
            end
        end
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc = pc;
                e.inst = inst;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int reset_cnt;
        reset_cnt = 0;
        // Reset held two cycles with a valid beat offered.
        step(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h104, 32'h00500093, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_imm", bus.out_imm, 32'h0);
        check("rst_fields", {bus.out_funct7, bus.out_rs2, bus.out_rs1, bus.out_funct3,
                             bus.out_rd, bus.out_opcode}, 32'h0);

        // addi x1,x0,5
        step(1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
        check("addi_valid", 32'(bus.out_valid), 32'h1);
        check("addi_rd", 32'(bus.out_rd), 32'h1);
        check("addi_rs1", 32'(bus.out_rs1), 32'h0);
        check("addi_f3", 32'(bus.out_funct3), 32'h0);
        check("addi_imm", bus.out_imm, 32'h5);

        // Back-to-back S/B/U/J formats.
        step(1'b1, 32'h4, 32'h00112423, 1'b1, 1'b0, 1'b0);
        check("sw_imm", bus.out_imm, 32'h8);
        check("sw_rs2", 32'(bus.out_rs2), 32'h1);
        check("sw_rs1", 32'(bus.out_rs1), 32'h2);
        step(1'b1, 32'h8, 32'hFE000EE3, 1'b1, 1'b0, 1'b0);
        check("beq_imm", bus.out_imm, 32'hFFFFFFFC);
        step(1'b1, 32'hC, 32'h123452B7, 1'b1, 1'b0, 1'b0);
        check("lui_imm", bus.out_imm, 32'h12345000);
        step(1'b1, 32'h10, 32'h008000EF, 1'b1, 1'b0, 1'b0);
        check("jal_imm", bus.out_imm, 32'h8);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Fill while stalled; Fetch holds the rejected beat, then drain in order.
        pc_next = 32'h0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            logic acc;
            acc = model_q.size() < DEPTH;
            step(1'b1, pc_next, 32'h00000013 | (pc_next << 20), 1'b0, 1'b0, 1'b0);
            if (acc) pc_next += 4;
        end
        check("full_in_ready", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            logic acc;
            acc = (model_q.size() < DEPTH) || (model_q.size() != 0);
            step(pc_next < 32'h20, pc_next, 32'h00000013 | (pc_next << 20), 1'b1, 1'b0, 1'b0);
            if (acc && pc_next < 32'h20) pc_next += 4;
        end
        while (model_q.size() != 0) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with two entries queued and a beat offered.
        step(1'b1, 32'h40, 32'h00A00113, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h44, 32'h00B00193, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h48, 32'h00C00213, 1'b0, 1'b1, 1'b0);
        check("flush_out_valid", 32'(bus.out_valid), 32'h0);
        step(1'b1, 32'h80, 32'h00D00293, 1'b0, 1'b0, 1'b0);
        check("post_flush_pc", bus.out_pc, 32'h80);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("post_flush_alone", 32'(bus.out_valid), 32'h0);

`ifdef DECODE_ILLEGAL_CHECK_EN
        step(1'b1, 32'h90, 32'h00000000, 1'b1, 1'b0, 1'b0);
        check("illegal_zero", 32'(bus.out_illegal), 32'h1);
        step(1'b1, 32'h94, 32'h0000007F, 1'b1, 1'b0, 1'b0);
        check("illegal_7f", 32'(bus.out_illegal), 32'h1);
        step(1'b1, 32'h98, 32'h00500093, 1'b1, 1'b0, 1'b0);
        check("legal_addi", 32'(bus.out_illegal), 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
`endif

        // Randomized traffic against the queue model.
        pc_next = 32'h1000;
        for (int c = 0; c < 2000; c++) begin
            logic [31:0] w;
            logic v, r, f, rs;
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            f  = ($urandom_range(0, 31) == 0);
            rs = ($urandom_range(0, 199) == 0) && (reset_cnt < 5);
            if (rs) reset_cnt++;
            if (v && model_q.size() < DEPTH) begin
                step(v, pc_next, w, r, f, rs);
                pc_next += 4;
            end else begin
                step(v, pc_next, w, r, f, rs);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
